pia8255_bus_master: RTL and testbench

- Clocked initiator for 8255-style PIA register cycles, i.e. the CPU-side master of the 4-register PIA bus (port A, port B, port C, control).
- Takes single-beat read/write requests from internal logic (sequencer, Z80 bridge) and emits timed A/CS/RD/WR/D strobes with programmable setup, strobe and hold widths.
- Returns read data and a done pulse.
- Drives an on-chip PIA core or an external 8255 on the expansion connector.

---
 rtl/pia8255_bus_master.sv | 176 +++++++++++++++++
 tb/tb_pia8255_bus_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pia8255_bus_master.sv
// Clocked initiator for 8255-style PIA register cycles with programmable setup/strobe/hold widths.
// Optional port C bit set/reset request path enabled by defining PIA_BSR_EN.
module pia8255_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1,
    parameter int CNT_W      = 4
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic       I_REQ,
    input  logic       I_REQ_WR,
    input  logic [1:0] I_REQ_A,
    input  logic [7:0] I_REQ_D,
`ifdef PIA_BSR_EN
    input  logic       I_REQ_BSR,
    input  logic [2:0] I_REQ_BIT,
    input  logic       I_REQ_VAL,
`endif
    output logic       O_BUSY,
    output logic       O_DONE,
    output logic [7:0] O_RDATA,
    output logic [1:0] O_A,
    output logic       O_CS,
    output logic       O_RD,
    output logic       O_WR,
    output logic [7:0] O_D,
    output logic       O_DOE,
    output logic [2:0] O_STATE,
    input  logic [7:0] I_D
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Counters load "clocks remaining minus one" so a phase ends when the counter reads zero.
    localparam logic [CNT_W-1:0] C_SETUP_LAST  = (SETUP_CYC  > 0) ? CNT_W'(SETUP_CYC  - 1) : '0;
    localparam logic [CNT_W-1:0] C_STROBE_LAST = (STROBE_CYC > 0) ? CNT_W'(STROBE_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] C_HOLD_LAST   = (HOLD_CYC   > 0) ? CNT_W'(HOLD_CYC   - 1) : '0;

    logic       w_req_wr;
    logic [1:0] w_req_a;
    logic [7:0] w_req_d;

`ifdef PIA_BSR_EN
    // A bit set/reset request is a control-register write carrying the BSR control word.
    assign w_req_wr = I_REQ_BSR | I_REQ_WR;
    assign w_req_a  = I_REQ_BSR ? 2'b11 : I_REQ_A;
    assign w_req_d  = I_REQ_BSR ? {4'b0000, I_REQ_BIT, I_REQ_VAL} : I_REQ_D;
`else
    assign w_req_wr = I_REQ_WR;
    assign w_req_a  = I_REQ_A;
    assign w_req_d  = I_REQ_D;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cyc_wr;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_rdata;
    logic [1:0]       r_a;
    logic             r_cs;
    logic             r_rd;
    logic             r_wr;
    logic [7:0]       r_d;
    logic             r_doe;

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cyc_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rdata  <= 8'h00;
            r_a      <= 2'b00;
            r_cs     <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_d      <= 8'h00;
            r_doe    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (I_REQ) begin
                        r_cyc_wr <= w_req_wr;
                        r_a      <= w_req_a;
                        r_busy   <= 1'b1;
                        r_cs     <= 1'b1;
                        if (w_req_wr) begin
                            r_d   <= w_req_d;
                            r_doe <= 1'b1;
                        end
                        if (SETUP_CYC > 0) begin
                            r_state <= S_SETUP;
                            r_cnt   <= C_SETUP_LAST;
                        end else begin
                            r_state <= S_STROBE;
                            r_cnt   <= C_STROBE_LAST;
                            r_rd    <= ~w_req_wr;
                            r_wr    <= w_req_wr;
                        end
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_STROBE;
                        r_cnt   <= C_STROBE_LAST;
                        r_rd    <= ~r_cyc_wr;
                        r_wr    <= r_cyc_wr;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == '0) begin
                        r_rd <= 1'b0;
                        r_wr <= 1'b0;
                        // Read data is sampled on the same edge that ends the strobe.
                        if (!r_cyc_wr) begin
                            r_rdata <= I_D;
                        end
                        if (HOLD_CYC > 0) begin
                            r_state <= S_HOLD;
                            r_cnt   <= C_HOLD_LAST;
                        end else begin
                            r_state <= S_DONE;
                            r_cs    <= 1'b0;
                            r_doe   <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_cs    <= 1'b0;
                        r_doe   <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    // Busy stays high through the done clock so a request there is not taken.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign O_BUSY  = r_busy;
    assign O_DONE  = r_done;
    assign O_RDATA = r_rdata;
    assign O_A     = r_a;
    assign O_CS    = r_cs;
    assign O_RD    = r_rd;
    assign O_WR    = r_wr;
    assign O_D     = r_d;
    assign O_DOE   = r_doe;
    assign O_STATE = r_state;

endmodule

// File: tb/tb_pia8255_bus_master.sv
// Bench for pia8255_bus_master: a default-timing instance and a minimum-timing instance
// (setup 0, strobe 1, hold 0) checked every clock against a cycle-offset reference model.
module tb_pia8255_bus_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT signals (index 0 = default, 1 = minimum) ----------------
  logic       req    [2];
  logic       req_wr [2];
  logic [1:0] req_a  [2];
  logic [7:0] req_d  [2];
  logic [7:0] i_d    [2];
  logic       bsr    [2];
  logic [2:0] bsr_bit[2];
  logic       bsr_val[2];

  logic       busy_o [2];
  logic       done_o [2];
  logic [7:0] rdata_o[2];
  logic [1:0] a_o    [2];
  logic       cs_o   [2];
  logic       rd_o   [2];
  logic       wr_o   [2];
  logic [7:0] d_o    [2];
  logic       doe_o  [2];
  logic [2:0] state_o[2];

  int p_s[2] = '{1, 0};
  int p_t[2] = '{3, 1};
  int p_h[2] = '{1, 0};

  pia8255_bus_master #(.SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(1), .CNT_W(4)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_REQ(req[0]), .I_REQ_WR(req_wr[0]),
    .I_REQ_A(req_a[0]), .I_REQ_D(req_d[0]),
`ifdef PIA_BSR_EN
    .I_REQ_BSR(bsr[0]), .I_REQ_BIT(bsr_bit[0]), .I_REQ_VAL(bsr_val[0]),
`endif
    .O_BUSY(busy_o[0]), .O_DONE(done_o[0]), .O_RDATA(rdata_o[0]), .O_A(a_o[0]),
    .O_CS(cs_o[0]), .O_RD(rd_o[0]), .O_WR(wr_o[0]), .O_D(d_o[0]), .O_DOE(doe_o[0]),
    .O_STATE(state_o[0]), .I_D(i_d[0])
  );

  pia8255_bus_master #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0), .CNT_W(4)) dut_min (
    .I_CLK(clk), .I_RESET(rst), .I_REQ(req[1]), .I_REQ_WR(req_wr[1]),
    .I_REQ_A(req_a[1]), .I_REQ_D(req_d[1]),
`ifdef PIA_BSR_EN
    .I_REQ_BSR(bsr[1]), .I_REQ_BIT(bsr_bit[1]), .I_REQ_VAL(bsr_val[1]),
`endif
    .O_BUSY(busy_o[1]), .O_DONE(done_o[1]), .O_RDATA(rdata_o[1]), .O_A(a_o[1]),
    .O_CS(cs_o[1]), .O_RD(rd_o[1]), .O_WR(wr_o[1]), .O_D(d_o[1]), .O_DOE(doe_o[1]),
    .O_STATE(state_o[1]), .I_D(i_d[1])
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A cycle is described by k = clocks since the accepting edge; every bus output is a
  // function of k against the setup/strobe/hold boundaries.
  bit         m_act  [2] = '{0, 0};
  int         m_k    [2] = '{0, 0};
  bit         m_cwr  [2] = '{0, 0};
  logic [1:0] m_a    [2] = '{2'b00, 2'b00};
  logic [7:0] m_d    [2] = '{8'h00, 8'h00};
  logic [7:0] m_rdata[2] = '{8'h00, 8'h00};

  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        m_act[j]   <= 1'b0;
        m_k[j]     <= 0;
        m_cwr[j]   <= 1'b0;
        m_a[j]     <= 2'b00;
        m_d[j]     <= 8'h00;
        m_rdata[j] <= 8'h00;
      end else if (m_act[j]) begin
        m_k[j] <= m_k[j] + 1;
        if (!m_cwr[j] && (m_k[j] + 1 == p_s[j] + p_t[j])) m_rdata[j] <= i_d[j];
        if (m_k[j] + 1 > p_s[j] + p_t[j] + p_h[j]) m_act[j] <= 1'b0;
      end else if (req[j]) begin
        m_act[j] <= 1'b1;
        m_k[j]   <= 0;
`ifdef PIA_BSR_EN
        if (bsr[j]) begin
          m_cwr[j] <= 1'b1;
          m_a[j]   <= 2'b11;
          m_d[j]   <= {4'b0000, bsr_bit[j], bsr_val[j]};
        end else begin
          m_cwr[j] <= req_wr[j];
          m_a[j]   <= req_a[j];
          if (req_wr[j]) m_d[j] <= req_d[j];
        end
`else
        m_cwr[j] <= req_wr[j];
        m_a[j]   <= req_a[j];
        if (req_wr[j]) m_d[j] <= req_d[j];
`endif
      end
    end
  end

  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      int  l;
      bit  in_str;
      l      = p_s[j] + p_t[j] + p_h[j];
      in_str = m_act[j] && (m_k[j] >= p_s[j]) && (m_k[j] < p_s[j] + p_t[j]);
      check($sformatf("busy%0d", j),  busy_o[j],  m_act[j]);
      check($sformatf("cs%0d", j),    cs_o[j],    m_act[j] && (m_k[j] < l));
      check($sformatf("done%0d", j),  done_o[j],  m_act[j] && (m_k[j] == l));
      check($sformatf("rd%0d", j),    rd_o[j],    in_str && !m_cwr[j]);
      check($sformatf("wr%0d", j),    wr_o[j],    in_str && m_cwr[j]);
      check($sformatf("doe%0d", j),   doe_o[j],   m_act[j] && m_cwr[j] && (m_k[j] < l));
      check($sformatf("a%0d", j),     a_o[j],     m_a[j]);
      check($sformatf("d%0d", j),     d_o[j],     m_d[j]);
      check($sformatf("rdata%0d", j), rdata_o[j], m_rdata[j]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cycle(input int j, input bit wr, input logic [1:0] a,
                           input logic [7:0] d, input int exp_lat);
    int  n;
    bit  got;
    @(negedge clk);
    req[j] = 1'b1; req_wr[j] = wr; req_a[j] = a; req_d[j] = d;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(negedge clk);
      req[j] = 1'b0;
      n++;
      if (done_o[j]) got = 1;
    end
    check($sformatf("latency%0d", j), n, exp_lat);
  endtask

  task automatic randomize_inputs();
    for (int j = 0; j < 2; j++) begin
      req[j]     = ($urandom_range(0, 3) == 0);
      req_wr[j]  = 1'($urandom_range(0, 1));
      req_a[j]   = 2'($urandom_range(0, 3));
      req_d[j]   = 8'($urandom_range(0, 255));
      i_d[j]     = 8'($urandom_range(0, 255));
`ifdef PIA_BSR_EN
      bsr[j]     = ($urandom_range(0, 7) == 0);
`else
      bsr[j]     = 1'b0;
`endif
      bsr_bit[j] = 3'($urandom_range(0, 7));
      bsr_val[j] = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int j = 0; j < 2; j++) begin
      req[j] = 1'b0; req_wr[j] = 1'b0; req_a[j] = 2'b00; req_d[j] = 8'h00;
      i_d[j] = 8'h00; bsr[j] = 1'b0; bsr_bit[j] = 3'd0; bsr_val[j] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);

    // Default timing: write, then read with stable bus data.
    run_cycle(0, 1'b1, 2'b01, 8'h5A, 6);
    check("wr_a_held", a_o[0], 2'b01);
    check("wr_d_held", d_o[0], 8'h5A);
    i_d[0] = 8'hC3;
    run_cycle(0, 1'b0, 2'b10, 8'h00, 6);
    check("rdata_at_done", rdata_o[0], 8'hC3);
    i_d[0] = 8'h00;
    repeat (4) @(negedge clk);
    check("rdata_held", rdata_o[0], 8'hC3);

    // Request held continuously; mid-cycle requests must be dropped.
    req[0] = 1'b1; req_wr[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      req_a[0] = 2'($urandom_range(0, 3));
      req_d[0] = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    req[0] = 1'b0;
    repeat (8) @(negedge clk);

    // Minimum timing: strobe in the clock after accept, then async reset during strobe.
    run_cycle(1, 1'b1, 2'b00, 8'hA5, 2);
    @(negedge clk);
    req[1] = 1'b1; req_wr[1] = 1'b1; req_a[1] = 2'b01; req_d[1] = 8'h3C;
    @(negedge clk);
    req[1] = 1'b0;
    check("min_wr_before_reset", wr_o[1], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_cs", cs_o[1], 1'b0);
    check("rst_wr", wr_o[1], 1'b0);
    check("rst_doe", doe_o[1], 1'b0);
    check("rst_done", done_o[1], 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    run_cycle(1, 1'b1, 2'b10, 8'h81, 2);
    check("after_rst_d", d_o[1], 8'h81);

`ifdef PIA_BSR_EN
    @(negedge clk);
    bsr[0] = 1'b1; bsr_bit[0] = 3'd5; bsr_val[0] = 1'b1;
    run_cycle(0, 1'b0, 2'b00, 8'hFF, 6);
    bsr[0] = 1'b0;
    check("bsr_a", a_o[0], 2'b11);
    check("bsr_d", d_o[0], 8'h0B);
`endif

    // Randomized traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      randomize_inputs();
    end
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      req[j] = 1'b0; bsr[j] = 1'b0;
    end
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
